issue_arbiter: RTL and testbench
================================

Name: issue_arbiter

Overview:
- Issue-stage controller between the decode/schedule registers and the execute stages.
- Arbitrates one issue slot per cycle between the main stream and COP_NUMS coprocessor candidates.
- Tracks in-flight destination registers in a 32-entry scoreboard and blocks RAW and WAW hazards.
- Stops the main stream from starving under sustained coprocessor traffic, and drives the pipeline stall request.

Parameters:
- COP_NUMS, 1, number of coprocessor candidates (1..8).
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which an eligible main request overrides the cops (1..15).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- FLUSH  in  1  synchronous pipeline flush.
- STALL  in  1  downstream stall; freezes issue.
- MMU_WAIT  in  1  MMU wait; freezes issue.
- MAIN_REQ  in  1  main candidate valid.
- MAIN_RD / MAIN_RS1 / MAIN_RS2  in  5 each  main register indices.
- COP_REQ  in  COP_NUMS  per-cop candidate valid.
- COP_RD / COP_RS1 / COP_RS2  in  5*COP_NUMS each  per-cop register indices; cop k uses bits [5k+4:5k].
- WB_MAIN_VALID  in  1  main writeback this cycle.
- WB_MAIN_RD  in  5  main writeback register.
- WB_COP_VALID  in  COP_NUMS  cop writebacks this cycle.
- WB_COP_RD  in  5*COP_NUMS  cop writeback registers.
- GRANT_MAIN  out  1  main issues this cycle.
- GRANT_COP  out  COP_NUMS  one-hot cop issue.
- GRANT_RD  out  5  rd of the granted instruction; 0 when no grant.
- HAZARD_STALL  out  1  a request is pending but nothing issued.
- BUSY_MAP  out  32  registered scoreboard; bit 0 is always 0.

Behaviour:
- State:
  - busy[31:0], registered.
  - rr_ptr, clog2(COP_NUMS) bits; 0 width behaviour when COP_NUMS=1.
  - starve_cnt, 4 bits.
  - All reset to 0 asynchronously.
- Outputs while RST is high: all grants 0, GRANT_RD 0, HAZARD_STALL 0, BUSY_MAP 0.
- Writeback clear mask (wbclr): OR of a one-hot decode of every valid writeback rd; bit 0 is masked off.
- Effective busy: eb = busy & ~wbclr. A same-cycle writeback therefore unblocks a waiting consumer.
- Eligibility: a requester is eligible when REQ=1 and none of rs1, rs2 or rd is set in eb. Index 0 never blocks.
- Freeze: when STALL or MMU_WAIT is high, there are no grants, and rr_ptr and starve_cnt hold. busy is still updated by wbclr.
- Grant selection is combinational; at most one grant per cycle.
  - If main is eligible and starve_cnt == STARVE_LIMIT, GRANT_MAIN=1.
  - Else if any cop is eligible, grant the first eligible cop searching upward from rr_ptr, wrapping at COP_NUMS.
  - Else if main is eligible, GRANT_MAIN=1.
- GRANT_RD is combinational and equals the granted instruction's rd.
- HAZARD_STALL = (MAIN_REQ | any COP_REQ) & no grant & ~freeze & ~RST.
- Clock edge update:
  - busy <= (busy & ~wbclr) | onehot(GRANT_RD); bit 0 is forced to 0.
  - On a grant, set wins over a clear of the same register.
  - After granting cop k: rr_ptr <= (k+1) mod COP_NUMS.
  - starve_cnt <= 0 when main is granted or MAIN_REQ=0.
  - starve_cnt <= min(starve_cnt+1, STARVE_LIMIT) when main is eligible and a cop is granted.
  - Otherwise starve_cnt holds.
- FLUSH:
  - At the next edge, busy, starve_cnt and rr_ptr are cleared to 0.
  - In the FLUSH cycle itself all grants are forced to 0 and HAZARD_STALL is 0.
  - FLUSH has priority over freeze and over writeback.
- Latency: grant is 0-cycle from the request. The scoreboard effect is visible to the next cycle's eligibility.
- Requester protocol: a requester holds its REQ and fields until granted. It advances the same edge the grant is seen.
- Reset mid-operation: all state clears immediately. Pending writebacks arriving after reset are harmless because clearing an idle bit is a no-op.

Test Plan:
- Basic issue: MAIN_REQ, rd=5, rs1=1, rs2=2, empty scoreboard -> GRANT_MAIN=1, GRANT_RD=5; next cycle BUSY_MAP=0x00000020.
- RAW hazard and bypass:
  - busy[5]=1, main rs1=5 -> HAZARD_STALL=1, no grant.
  - Later, in the cycle with WB_MAIN_VALID=1 and WB_MAIN_RD=5 -> GRANT_MAIN=1 the same cycle, and busy[5] stays 1 (re-set).
- Cop priority and starvation, STARVE_LIMIT=4, COP_NUMS=1:
  - Continuous cop and main requests with no hazards -> cop is granted 4 cycles.
  - 5th cycle -> GRANT_MAIN=1, then starve_cnt=0.
- Round-robin with COP_NUMS=2, both cops requesting every cycle -> GRANT_COP sequence 01,10,01,10.
- Freeze and x0:
  - MMU_WAIT=1 with requests -> no grants, HAZARD_STALL=0, while a writeback still clears the busy bit.
  - rd=0 grant -> BUSY_MAP stays 0.
- Flush and reset:
  - FLUSH with busy=0xFFFFFFFE -> no grant that cycle; BUSY_MAP=0 next cycle.
  - Asynchronous RST pulse mid-cycle -> grants drop to 0 immediately.

Source files
------------

// File: rtl/issue_arbiter.sv
// issue_arbiter: picks one instruction per cycle to issue, choosing between the
// main stream and COP_NUMS coprocessor candidates. It keeps a 32-entry
// scoreboard of registers that are still being written, and holds back any
// instruction that would read or overwrite one of them (RAW/WAW hazards). It
// also makes sure the main stream is not starved by the coprocessors.
// Ports:
//   CLK, RST (async active-high), FLUSH (sync clear), STALL / MMU_WAIT (freeze)
//   MAIN_REQ / MAIN_RD / MAIN_RS1 / MAIN_RS2        main candidate
//   COP_REQ / COP_RD / COP_RS1 / COP_RS2            cop k uses bits [5k+4:5k]
//   WB_MAIN_VALID / WB_MAIN_RD, WB_COP_VALID / WB_COP_RD   writebacks
//   GRANT_MAIN, GRANT_COP (one-hot), GRANT_RD       combinational issue result
//   HAZARD_STALL                                    request pending, nothing issued
//   BUSY_MAP                                        registered scoreboard
module issue_arbiter #(
    parameter int unsigned COP_NUMS     = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  STALL,
    input  logic                  MMU_WAIT,
    input  logic                  MAIN_REQ,
    input  logic [4:0]            MAIN_RD,
    input  logic [4:0]            MAIN_RS1,
    input  logic [4:0]            MAIN_RS2,
    input  logic [COP_NUMS-1:0]   COP_REQ,
    input  logic [5*COP_NUMS-1:0] COP_RD,
    input  logic [5*COP_NUMS-1:0] COP_RS1,
    input  logic [5*COP_NUMS-1:0] COP_RS2,
    input  logic                  WB_MAIN_VALID,
    input  logic [4:0]            WB_MAIN_RD,
    input  logic [COP_NUMS-1:0]   WB_COP_VALID,
    input  logic [5*COP_NUMS-1:0] WB_COP_RD,
    output logic                  GRANT_MAIN,
    output logic [COP_NUMS-1:0]   GRANT_COP,
    output logic [4:0]            GRANT_RD,
    output logic                  HAZARD_STALL,
    output logic [31:0]           BUSY_MAP
);

    // With a single cop the pointer is kept as one bit that is always 0.
    localparam int unsigned PTR_W      = (COP_NUMS > 1) ? $clog2(COP_NUMS) : 1;
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

    logic [31:0]         busy_q, busy_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;

    logic [31:0]         wbclr;
    logic [31:0]         eb;
    logic                main_elig;
    logic [COP_NUMS-1:0] cop_elig;
    logic                freeze;
    logic                issue_en;
    logic                cop_hit;
    logic [PTR_W-1:0]    cop_idx;
    int                  scan;
    logic                grant_main_c;
    logic [COP_NUMS-1:0] grant_cop_c;
    logic                cop_granted_c;
    logic [4:0]          grant_rd_c;

    // Writeback clear mask; x0 is never tracked.
    always_comb begin
        wbclr = '0;
        if (WB_MAIN_VALID) wbclr[WB_MAIN_RD] = 1'b1;
        for (int k = 0; k < int'(COP_NUMS); k++) begin
            if (WB_COP_VALID[k]) wbclr[WB_COP_RD[5*k +: 5]] = 1'b1;
        end
        wbclr[0] = 1'b0;
    end

    // A writeback in this cycle already counts as free (same-cycle bypass).
    assign eb = busy_q & ~wbclr;

    // Eligibility: no source or destination still in flight.
    always_comb begin
        main_elig = MAIN_REQ & ~eb[MAIN_RS1] & ~eb[MAIN_RS2] & ~eb[MAIN_RD];
        cop_elig  = '0;
        for (int k = 0; k < int'(COP_NUMS); k++) begin
            cop_elig[k] = COP_REQ[k] & ~eb[COP_RS1[5*k +: 5]]
                        & ~eb[COP_RS2[5*k +: 5]] & ~eb[COP_RD[5*k +: 5]];
        end
    end

    assign freeze   = STALL | MMU_WAIT;
    assign issue_en = ~RST & ~FLUSH & ~freeze;

    // Round-robin search upward from rr_ptr, wrapping at COP_NUMS.
    always_comb begin
        cop_hit = 1'b0;
        cop_idx = '0;
        scan    = 0;
        for (int i = 0; i < int'(COP_NUMS); i++) begin
            scan = (int'(rr_ptr_q) + i) % int'(COP_NUMS);
            if (!cop_hit && cop_elig[PTR_W'(scan)]) begin
                cop_hit = 1'b1;
                cop_idx = PTR_W'(scan);
            end
        end
    end

    // Grant selection: starving main first, then cops, then main.
    always_comb begin
        grant_main_c = 1'b0;
        grant_cop_c  = '0;
        grant_rd_c   = 5'd0;
        if (issue_en) begin
            if (main_elig && (starve_cnt_q == STARVE_MAX)) begin
                grant_main_c = 1'b1;
            end else if (cop_hit) begin
                grant_cop_c[cop_idx] = 1'b1;
            end else if (main_elig) begin
                grant_main_c = 1'b1;
            end
        end
        if (grant_main_c) begin
            grant_rd_c = MAIN_RD;
        end else if (|grant_cop_c) begin
            grant_rd_c = COP_RD[5*int'(cop_idx) +: 5];
        end
    end

    assign cop_granted_c = |grant_cop_c;

    // Next-state: scoreboard, round-robin pointer and starvation counter.
    always_comb begin
        busy_d       = eb;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        // Set wins over a same-cycle clear of the granted rd.
        if (grant_main_c || cop_granted_c) busy_d[grant_rd_c] = 1'b1;
        busy_d[0] = 1'b0;
        if (!freeze) begin
            if (cop_granted_c) begin
                rr_ptr_d = (COP_NUMS > 1)
                         ? PTR_W'((int'(cop_idx) + 1) % int'(COP_NUMS)) : '0;
            end
            if (grant_main_c || !MAIN_REQ) begin
                starve_cnt_d = 4'd0;
            end else if (main_elig && cop_granted_c && (starve_cnt_q < STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
        if (FLUSH) begin
            busy_d       = '0;
            rr_ptr_d     = '0;
            starve_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q       <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= 4'd0;
        end else begin
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign GRANT_MAIN   = grant_main_c;
    assign GRANT_COP    = grant_cop_c;
    assign GRANT_RD     = grant_rd_c;
    assign HAZARD_STALL = (MAIN_REQ | (|COP_REQ)) & ~grant_main_c & ~cop_granted_c & issue_en;
    assign BUSY_MAP     = busy_q;

endmodule

// File: tb/tb_issue_arbiter.sv
// Bench for issue_arbiter (2 cops, starvation limit 4): directed scenarios
// followed by randomized traffic, all compared against a reference model.
module tb_issue_arbiter;

    localparam int NC  = 2;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst, flush, stall, mmu_wait;
    logic          main_req;
    logic [4:0]    main_rd, main_rs1, main_rs2;
    logic [NC-1:0] cop_req;
    logic [5*NC-1:0] cop_rd, cop_rs1, cop_rs2;
    logic          wb_main_valid;
    logic [4:0]    wb_main_rd;
    logic [NC-1:0] wb_cop_valid;
    logic [5*NC-1:0] wb_cop_rd;
    logic          grant_main;
    logic [NC-1:0] grant_cop;
    logic [4:0]    grant_rd;
    logic          hazard_stall;
    logic [31:0]   busy_map;

    int checks   = 0;
    int failures = 0;

    // Reference model state and per-cycle expectations.
    logic [31:0]   m_busy;
    int            m_rr;
    int            m_starve;
    logic [31:0]   m_eb;
    bit            m_mok;
    int            m_pick;
    logic          e_gm;
    logic [NC-1:0] e_gc;
    logic [4:0]    e_rd;
    logic          e_hs;

    issue_arbiter #(.COP_NUMS(NC), .STARVE_LIMIT(LIM)) dut (
        .CLK(clk), .RST(rst), .FLUSH(flush), .STALL(stall), .MMU_WAIT(mmu_wait),
        .MAIN_REQ(main_req), .MAIN_RD(main_rd), .MAIN_RS1(main_rs1), .MAIN_RS2(main_rs2),
        .COP_REQ(cop_req), .COP_RD(cop_rd), .COP_RS1(cop_rs1), .COP_RS2(cop_rs2),
        .WB_MAIN_VALID(wb_main_valid), .WB_MAIN_RD(wb_main_rd),
        .WB_COP_VALID(wb_cop_valid), .WB_COP_RD(wb_cop_rd),
        .GRANT_MAIN(grant_main), .GRANT_COP(grant_cop), .GRANT_RD(grant_rd),
        .HAZARD_STALL(hazard_stall), .BUSY_MAP(busy_map)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush = 0; stall = 0; mmu_wait = 0;
        main_req = 0; main_rd = 0; main_rs1 = 0; main_rs2 = 0;
        cop_req = '0; cop_rd = '0; cop_rs1 = '0; cop_rs2 = '0;
        wb_main_valid = 0; wb_main_rd = 0; wb_cop_valid = '0; wb_cop_rd = '0;
    endtask

    task automatic set_main(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        main_req = 1; main_rd = rd; main_rs1 = rs1; main_rs2 = rs2;
    endtask

    task automatic set_cop(input int k, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        cop_req[k] = 1'b1;
        cop_rd[5*k +: 5] = rd; cop_rs1[5*k +: 5] = rs1; cop_rs2[5*k +: 5] = rs2;
    endtask

    task automatic model_reset();
        m_busy = '0; m_rr = 0; m_starve = 0;
    endtask

    function automatic bit is_free(input logic [31:0] e, input logic [4:0] r);
        return (r == 5'd0) || (e[r] == 1'b0);
    endfunction

    // What the issue stage should do this cycle, given current inputs and model state.
    task automatic model_eval();
        logic [31:0] clr;
        bit          cok [NC];
        int          c;
        clr = '0;
        if (wb_main_valid) clr[wb_main_rd] = 1'b1;
        for (int k = 0; k < NC; k++) if (wb_cop_valid[k]) clr[wb_cop_rd[5*k +: 5]] = 1'b1;
        clr[0] = 1'b0;
        m_eb  = m_busy & ~clr;
        m_mok = main_req && is_free(m_eb, main_rs1) && is_free(m_eb, main_rs2) && is_free(m_eb, main_rd);
        for (int k = 0; k < NC; k++)
            cok[k] = cop_req[k] && is_free(m_eb, cop_rs1[5*k +: 5])
                     && is_free(m_eb, cop_rs2[5*k +: 5]) && is_free(m_eb, cop_rd[5*k +: 5]);
        e_gm = 0; e_gc = '0; e_rd = 0; e_hs = 0; m_pick = -1;
        if (!rst && !flush && !stall && !mmu_wait) begin
            for (int i = 0; i < NC; i++) begin
                c = (m_rr + i) % NC;
                if (m_pick < 0 && cok[c]) m_pick = c;
            end
            if (m_mok && m_starve == LIM) begin
                e_gm = 1; m_pick = -1;
            end else if (m_pick >= 0) begin
                e_gc[m_pick] = 1'b1;
                e_rd = cop_rd[5*m_pick +: 5];
            end else if (m_mok) begin
                e_gm = 1;
            end
            if (e_gm) e_rd = main_rd;
            e_hs = (main_req || (cop_req != '0)) && !e_gm && (e_gc == '0);
        end
    endtask

    task automatic model_commit();
        if (flush) begin
            model_reset();
        end else begin
            m_busy = m_eb;
            if (e_gm || e_gc != '0) m_busy[e_rd] = 1'b1;
            m_busy[0] = 1'b0;
            if (!(stall || mmu_wait)) begin
                if (e_gc != '0) m_rr = (m_pick + 1) % NC;
                if (e_gm || !main_req) m_starve = 0;
                else if (m_mok && e_gc != '0 && m_starve < LIM) m_starve++;
            end
        end
    endtask

    task automatic eval_and_check();
        #1;
        model_eval();
        chk("grant_main", 32'(grant_main), 32'(e_gm));
        chk("grant_cop", 32'(grant_cop), 32'(e_gc));
        chk("grant_rd", 32'(grant_rd), 32'(e_rd));
        chk("hazard_stall", 32'(hazard_stall), 32'(e_hs));
        chk("busy_map", busy_map, m_busy);
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
    endtask

    logic [NC-1:0] rr_exp [4];

    initial begin
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1; idle(); model_reset();

        // Reset: requests present but nothing may issue.
        @(negedge clk);
        set_main(5, 1, 2);
        eval_and_check();
        chk("rst_grant_main", 32'(grant_main), 32'd0);
        chk("rst_busy", busy_map, 32'd0);
        @(negedge clk);
        rst = 0;

        // Basic issue.
        eval_and_check();
        chk("basic_gm", 32'(grant_main), 32'd1);
        chk("basic_rd", 32'(grant_rd), 32'd5);
        advance();
        idle();
        eval_and_check();
        chk("basic_busy", busy_map, 32'h20);
        advance();

        // RAW hazard, then same-cycle writeback bypass with re-set.
        set_main(6, 5, 0);
        eval_and_check();
        chk("raw_hs", 32'(hazard_stall), 32'd1);
        chk("raw_nogrant", 32'(grant_main), 32'd0);
        advance();
        set_main(5, 5, 0);
        wb_main_valid = 1; wb_main_rd = 5;
        eval_and_check();
        chk("bypass_gm", 32'(grant_main), 32'd1);
        advance();
        idle();
        wb_main_valid = 1; wb_main_rd = 5;
        eval_and_check();
        chk("bypass_reset_busy", busy_map, 32'h20);
        advance();
        idle();
        eval_and_check();
        chk("wb_clear", busy_map, 32'h0);
        advance();

        // Starvation: 4 cop grants, then main, then cop again.
        set_main(0, 0, 0);
        set_cop(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            eval_and_check();
            chk("starve_cop", 32'(grant_cop), 32'b01);
            advance();
        end
        eval_and_check();
        chk("starve_main", 32'(grant_main), 32'd1);
        advance();
        eval_and_check();
        chk("starve_after", 32'(grant_cop), 32'b01);
        advance();

        // Round robin from a flushed pointer.
        idle(); flush = 1;
        eval_and_check();
        advance();
        idle();
        set_cop(0, 0, 0, 0);
        set_cop(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            eval_and_check();
            chk("rr_seq", 32'(grant_cop), 32'(rr_exp[i]));
            advance();
        end

        // Freeze still lets writebacks clear the scoreboard.
        idle(); set_main(7, 0, 0);
        eval_and_check();
        advance();
        idle(); mmu_wait = 1;
        set_main(8, 0, 0); set_cop(0, 9, 0, 0);
        wb_main_valid = 1; wb_main_rd = 7;
        eval_and_check();
        chk("freeze_gm", 32'(grant_main), 32'd0);
        chk("freeze_gc", 32'(grant_cop), 32'd0);
        chk("freeze_hs", 32'(hazard_stall), 32'd0);
        advance();
        idle();
        eval_and_check();
        chk("freeze_wb_busy", busy_map, 32'h0);
        advance();

        // rd = 0 never enters the scoreboard.
        set_main(0, 0, 0);
        eval_and_check();
        chk("x0_gm", 32'(grant_main), 32'd1);
        advance();
        idle();
        eval_and_check();
        chk("x0_busy", busy_map, 32'h0);
        advance();

        // Fill every register, then flush.
        for (int r = 1; r < 32; r++) begin
            idle(); set_main(5'(r), 0, 0);
            eval_and_check();
            advance();
        end
        idle();
        eval_and_check();
        chk("full_busy", busy_map, 32'hFFFF_FFFE);
        advance();
        idle(); flush = 1; set_main(0, 0, 0);
        eval_and_check();
        chk("flush_gm", 32'(grant_main), 32'd0);
        chk("flush_hs", 32'(hazard_stall), 32'd0);
        advance();
        idle();
        eval_and_check();
        chk("flush_busy", busy_map, 32'h0);
        advance();

        // Randomized traffic on a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            idle();
            flush    = ($urandom_range(0, 31) == 0);
            stall    = ($urandom_range(0, 9) == 0);
            mmu_wait = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) != 0)
                set_main(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            for (int k = 0; k < NC; k++)
                if ($urandom_range(0, 2) != 0)
                    set_cop(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            wb_main_valid = 1'($urandom_range(0, 1));
            wb_main_rd    = 5'($urandom_range(0, 7));
            for (int k = 0; k < NC; k++) begin
                wb_cop_valid[k]     = 1'($urandom_range(0, 1));
                wb_cop_rd[5*k +: 5] = 5'($urandom_range(0, 7));
            end
            eval_and_check();
            advance();
        end

        // Asynchronous reset mid-cycle drops grants at once.
        idle(); flush = 1;
        eval_and_check();
        advance();
        idle(); set_main(3, 0, 0);
        eval_and_check();
        advance();
        idle(); set_main(4, 0, 0);
        eval_and_check();
        chk("pre_rst_gm", 32'(grant_main), 32'd1);
        #1 rst = 1;
        #1;
        chk("async_rst_gm", 32'(grant_main), 32'd0);
        chk("async_rst_rd", 32'(grant_rd), 32'd0);
        chk("async_rst_hs", 32'(hazard_stall), 32'd0);
        chk("async_rst_busy", busy_map, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        idle();
        wb_main_valid = 1; wb_main_rd = 4;
        eval_and_check();
        advance();
        idle();
        eval_and_check();
        chk("post_rst_busy", busy_map, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
